// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arb_pkg;

  localparam int NREQ          = 2;
  localparam int STROBE_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus for dmem_arbiter; slave is the arbiter's view.
interface dmem_arbiter_if #(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
);

  logic             req0, we0, gnt0, rvalid0;
  logic [ADDRW-1:0] addr0;
  logic [DATAW-1:0] wdata0, rdata0;

  logic             req1, we1, gnt1, rvalid1;
  logic [ADDRW-1:0] addr1;
  logic [DATAW-1:0] wdata1, rdata1;

  logic             mem_re, mem_we, mem_valid;
  logic [ADDRW-1:0] mem_addr;
  logic [DATAW-1:0] mem_din, mem_dout;
  logic             busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_dout, mem_valid,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_re, mem_we, mem_addr, mem_din, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_dout, mem_valid,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_re, mem_we, mem_addr, mem_din, busy
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner select. Fixed priority (requester 0 first) by default;
// round-robin on simultaneous requests when DMEM_ARB_RR_EN is defined.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
`ifdef DMEM_ARB_RR_EN
  input  logic            rr_last,
`endif
  output logic            valid,
  output logic            winner
);

  // NOTE: every output gets a value on every path, so no latch can be inferred.
  always_comb begin
    valid = |req;
`ifdef DMEM_ARB_RR_EN
    winner = (req == 2'b11) ? ~rr_last : req[1];
`else
    winner = ~req[0];
`endif
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter/sequencer in front of the 3-cycle single-port data memory.
// Optional round-robin arbitration: define DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDRW = 32,
  parameter int DATAW = 32
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus
);

  state_t            state;
  logic              owner;
  logic              we_q;
  logic              mem_re_q, mem_we_q, busy_q;
  logic [ADDRW-1:0]  addr_q;
  logic [DATAW-1:0]  din_q, rd_q, rdata0_q, rdata1_q;
  logic [NREQ-1:0]   gnt_q, rvalid_q;

  logic [NREQ-1:0]   req;
  logic              pick_valid, pick_winner;
  logic              sel_we;
  logic [ADDRW-1:0]  sel_addr;
  logic [DATAW-1:0]  sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic              rr_last;
`endif

  assign req = {bus.req1, bus.req0};

  dmem_arb_pick u_pick (
    .req     (req),
`ifdef DMEM_ARB_RR_EN
    .rr_last (rr_last),
`endif
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  assign sel_we    = pick_winner ? bus.we1    : bus.we0;
  assign sel_addr  = pick_winner ? bus.addr1  : bus.addr0;
  assign sel_wdata = pick_winner ? bus.wdata1 : bus.wdata0;

  // Outputs are registered, so each state's strobe action is visible one
  // cycle later: the strobe is high exactly during ACCESS and the first WAIT cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rd_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
`ifdef DMEM_ARB_RR_EN
      rr_last  <= 1'b1;
`endif
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner              <= pick_winner;
            we_q               <= sel_we;
            addr_q             <= sel_addr;
            din_q              <= sel_wdata;
            gnt_q[pick_winner] <= 1'b1;
            busy_q             <= 1'b1;
`ifdef DMEM_ARB_RR_EN
            rr_last            <= pick_winner;
`endif
            state              <= ISSUE;
          end
        end
        ISSUE: begin
          mem_re_q <= ~we_q;
          mem_we_q <= we_q;
          state    <= ACCESS;
        end
        ACCESS: state <= WAIT;
        WAIT: begin
          // Dropping here caps the strobe at two cycles even if mem_valid is late.
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (bus.mem_valid) begin
            rd_q  <= bus.mem_dout;
            state <= RESP;
          end
        end
        RESP: begin
          rvalid_q[owner] <= 1'b1;
          if (owner) rdata1_q <= rd_q;
          else       rdata0_q <= rd_q;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0     = gnt_q[0];
  assign bus.gnt1     = gnt_q[1];
  assign bus.rvalid0  = rvalid_q[0];
  assign bus.rvalid1  = rvalid_q[1];
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 3-cycle memory model.
module tb_dmem_arbiter;

  localparam int ADDRW = 32;
  localparam int DATAW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  dmem_arbiter #(.ADDRW(ADDRW), .DATAW(DATAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: one access per strobe burst, taken on its first cycle,
  // completion pulse in the following cycle.
  logic [31:0] mem [64];
  logic        strobe;
  logic        strobe_d = 1'b0;
  int          enables  = 0;

  assign strobe = bus.mem_re | bus.mem_we;

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_dout  = '0;
    mem[4]        = 32'hDEADBEEF;
  end

  always @(posedge clk) begin
    if (strobe && !strobe_d) begin
      enables       <= enables + 1;
      bus.mem_valid <= 1'b1;
      if (bus.mem_we) mem[bus.mem_addr[7:2]] = bus.mem_din;
      else            bus.mem_dout <= mem[bus.mem_addr[7:2]];
    end else begin
      bus.mem_valid <= 1'b0;
    end
    strobe_d <= strobe;
  end

  // Continuous protocol monitor, sampled mid-cycle.
  int run      = 0;
  int idle_cnt = 0;
  int we_cyc   = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (strobe) run++;
      else        run = 0;
      check("strobe_run_le2", 64'(run <= 2), 1);
      if (strobe) check("strobe_only_busy", bus.busy, 1);
      check("gnt_rvalid0_excl", bus.gnt0 & bus.rvalid0, 0);
      check("gnt_rvalid1_excl", bus.gnt1 & bus.rvalid1, 0);
      if (!bus.busy)  idle_cnt++;
      if (bus.mem_we) we_cyc++;
    end else begin
      run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output logic seen);
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bus.gnt0 | bus.gnt1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rvalid(output logic seen);
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bus.rvalid0 | bus.rvalid1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic exp_winner(input int k);
`ifdef DMEM_ARB_RR_EN
    return k[0];
`else
    return (k >= 4);
`endif
  endfunction

  logic seen;
  logic w;
  int   n0, n1, we_snap, en_snap, idle_snap;
  int   g [3];

  initial begin
    rst = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    tick();
    tick();

    // Reset state
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_gnt1", bus.gnt1, 0);
    check("rst_rvalid0", bus.rvalid0, 0);
    check("rst_rvalid1", bus.rvalid1, 0);
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    rst = 1'b1;

    // Single read: req at cycle 0, gnt at 1, strobe 2-3, rvalid at 5
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    tick();
    check("rd_gnt0_c1", bus.gnt0, 1);
    check("rd_busy_c1", bus.busy, 1);
    check("rd_re_c1", bus.mem_re, 0);
    bus.req0 = 1'b0;
    tick();
    check("rd_re_c2", bus.mem_re, 1);
    check("rd_we_c2", bus.mem_we, 0);
    check("rd_addr_c2", bus.mem_addr, 32'h10);
    check("rd_gnt0_c2", bus.gnt0, 0);
    tick();
    check("rd_re_c3", bus.mem_re, 1);
    tick();
    check("rd_re_c4", bus.mem_re, 0);
    check("rd_rvalid0_c4", bus.rvalid0, 0);
    tick();
    check("rd_rvalid0_c5", bus.rvalid0, 1);
    check("rd_rvalid1_c5", bus.rvalid1, 0);
    check("rd_rdata0_c5", bus.rdata0, 32'hDEADBEEF);
    check("rd_busy_c5", bus.busy, 0);
    tick();
    check("rd_rvalid0_c6", bus.rvalid0, 0);
    check("rd_rdata0_hold", bus.rdata0, 32'hDEADBEEF);

    // Write 0x24 = 0x12345678 from requester 1
    we_snap = we_cyc;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h24; bus.wdata1 = 32'h12345678;
    tick();
    check("wr_gnt1", bus.gnt1, 1);
    check("wr_gnt0", bus.gnt0, 0);
    bus.req1 = 1'b0;
    tick();
    check("wr_we_c2", bus.mem_we, 1);
    check("wr_re_c2", bus.mem_re, 0);
    check("wr_din_c2", bus.mem_din, 32'h12345678);
    check("wr_addr_c2", bus.mem_addr, 32'h24);
    tick();
    check("wr_we_c3", bus.mem_we, 1);
    check("wr_addr_c3", bus.mem_addr, 32'h24);
    tick();
    check("wr_we_c4", bus.mem_we, 0);
    tick();
    check("wr_rvalid1", bus.rvalid1, 1);
    check("wr_rvalid0", bus.rvalid0, 0);
    check("wr_we_cycles", we_cyc - we_snap, 2);

    // Read back from requester 1
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    wait_gnt(seen);
    check("rb_gnt_seen", seen, 1);
    check("rb_gnt1", bus.gnt1, 1);
    bus.req1 = 1'b0;
    wait_rvalid(seen);
    check("rb_rvalid_seen", seen, 1);
    check("rb_rvalid1", bus.rvalid1, 1);
    check("rb_rdata1", bus.rdata1, 32'h12345678);
    check("rb_rdata0_hold", bus.rdata0, 32'hDEADBEEF);

    // Contention: both held, four transactions each
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h24;
    n0 = 4;
    n1 = 4;
    for (int k = 0; k < 8; k++) begin
      wait_gnt(seen);
      check("cont_gnt_seen", seen, 1);
      w = bus.gnt1;
      check("cont_order", w, exp_winner(k));
      if (w) begin
        n1--;
        if (n1 == 0) bus.req1 = 1'b0;
      end else begin
        n0--;
        if (n0 == 0) bus.req0 = 1'b0;
      end
      wait_rvalid(seen);
      check("cont_rvalid_seen", seen, 1);
      check("cont_rvalid_owner", {bus.rvalid1, bus.rvalid0}, w ? 2'b10 : 2'b01);
      if (w) check("cont_rdata1", bus.rdata1, 32'h12345678);
      else   check("cont_rdata0", bus.rdata0, 32'hDEADBEEF);
    end

    // Back-to-back: req0 held for three reads
    en_snap  = enables;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    for (int i = 0; i < 3; i++) begin
      wait_gnt(seen);
      check("b2b_gnt_seen", seen, 1);
      check("b2b_gnt0", bus.gnt0, 1);
      g[i] = cyc;
      if (i == 0) idle_snap = idle_cnt;
      if (i == 2) bus.req0 = 1'b0;
    end
    wait_rvalid(seen);
    check("b2b_rvalid_seen", seen, 1);
    check("b2b_rvalid0", bus.rvalid0, 1);
    check("b2b_spacing_01", g[1] - g[0], 5);
    check("b2b_spacing_12", g[2] - g[1], 5);
    check("b2b_idle_cycles", idle_cnt - idle_snap, 2);
    check("b2b_enables", enables - en_snap, 3);

    // Reset during the strobe
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h24;
    wait_gnt(seen);
    check("mid_gnt_seen", seen, 1);
    bus.req0 = 1'b0;
    tick();
    check("mid_re_before", bus.mem_re, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_re_async", bus.mem_re, 0);
    check("mid_we_async", bus.mem_we, 0);
    check("mid_busy_async", bus.busy, 0);
    check("mid_rdata0_cleared", bus.rdata0, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_no_rvalid", bus.rvalid0 | bus.rvalid1, 0);
      check("mid_idle", bus.busy, 0);
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h10;
    wait_gnt(seen);
    check("post_gnt_seen", seen, 1);
    check("post_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    wait_rvalid(seen);
    check("post_rvalid_seen", seen, 1);
    check("post_rvalid0", bus.rvalid0, 1);
    check("post_rdata0", bus.rdata0, 32'hDEADBEEF);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
